burst_master_param: RTL and testbench

BURST_MASTER_PARAM -- requirements
Module: burst_master_param

---
 rtl/burst_master_param.sv | 166 ++++++++++++++++
 tb/tb_burst_master_param.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_master_param.sv
// Parameterised burst master: sends L incrementing words from a latched base over a
// 4-phase req/ack handshake, with a per-phase timeout and done/err completion pulses.

function automatic int burst_master_param_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
endfunction

module burst_master_param #(
    parameter int  DATA_W    = 8,
    parameter int  MAX_BURST = 16,
    parameter int  TIMEOUT   = 255,
    localparam int CNT_W     = burst_master_param_clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] base,
    input  logic              ack,
    output logic              req,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  xfer_cnt
);

    // The phase timer only has to reach TIMEOUT-1 before the phase is abandoned.
    localparam int               TMR_W    = (TIMEOUT < 2) ? 1 : burst_master_param_clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAITLOW = 3'd2,
        ST_CLEANUP = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic              phase_expired;

    assign phase_expired = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            timer_q <= '0;
            len_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            len_q   <= len_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        timer_d = timer_q + TMR_W'(1);
        len_d   = len_q;
        base_d  = base_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = timer_q;
                if (start && (len != '0)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    data_d  = base;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    timer_d = '0;
                    len_d   = (len > MAX_LEN) ? MAX_LEN : len;
                    base_d  = base;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_WAITLOW;
                    req_d   = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = '0;
                end else if (phase_expired) begin
                    state_d = ST_ERROR;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    timer_d = '0;
                end
            end
            ST_WAITLOW: begin
                // cnt_q already counts the word just acknowledged, so it is also the next offset.
                if (!ack) begin
                    timer_d = '0;
                    if (cnt_q == len_q) begin
                        state_d = ST_CLEANUP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        data_d  = base_q + DATA_W'(cnt_q);
                    end
                end else if (phase_expired) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    timer_d = '0;
                end
            end
            ST_CLEANUP, ST_ERROR: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                timer_d = timer_q;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                data_d  = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                timer_d = '0;
                len_d   = '0;
                base_d  = '0;
            end
        endcase
    end

    assign req      = req_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_burst_master_param.sv
// Bench for burst_master_param: a per-cycle timeline of expected outputs is computed from
// burst length, base and the scripted receiver delays, then compared against the DUT.

module tb_burst_master_param;

    localparam int DATA_W = 8;
    localparam int MAX_B  = 16;
    localparam int TMO    = 8;
    localparam int CNT_W  = 5;
    localparam int N      = 8192;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] base;
    logic              ack;
    logic              req;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  xfer_cnt;

    burst_master_param #(
        .DATA_W(DATA_W),
        .MAX_BURST(MAX_B),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .base(base),
        .ack(ack),
        .req(req),
        .data(data),
        .busy(busy),
        .done(done),
        .err(err),
        .xfer_cnt(xfer_cnt)
    );

    // Planned inputs and expected outputs, indexed by cycle number.
    bit                p_rst   [N];
    bit                p_start [N];
    bit                p_ack   [N];
    logic [CNT_W-1:0]  p_len   [N];
    logic [DATA_W-1:0] p_base  [N];
    bit                e_chk   [N];
    bit                e_req   [N];
    bit                e_busy  [N];
    bit                e_done  [N];
    bit                e_err   [N];
    logic [DATA_W-1:0] e_data  [N];
    logic [CNT_W-1:0]  e_cnt   [N];

    int cyc    = -1;
    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] hold_data;
    int                hold_cnt;

    logic [DATA_W-1:0] rise_words[$];
    int   done_count, err_count, last_done_cyc, last_err_cyc, cnt_at_done, cnt_at_err;
    logic prev_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int c, input logic [31:0] act,
                               input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, expv);
        end
    endtask

    task automatic applyStimulus(input int c);
        if (c >= 0 && c < N) begin
            rst   = p_rst[c];
            start = p_start[c];
            ack   = p_ack[c];
            len   = p_len[c];
            base  = p_base[c];
        end else begin
            rst   = 1'b0;
            start = 1'b0;
            ack   = 1'b0;
            len   = '0;
            base  = '0;
        end
    endtask

    function automatic void set_exp(int c, bit rq, logic [DATA_W-1:0] d, bit b, bit dn,
                                    bit er, int cnt);
        e_chk[c]  = 1'b1;
        e_req[c]  = rq;
        e_data[c] = d;
        e_busy[c] = b;
        e_done[c] = dn;
        e_err[c]  = er;
        e_cnt[c]  = CNT_W'(cnt);
    endfunction

    // Idle cycles: outputs rest, ack toggles randomly, optionally start=1 with len=0.
    task automatic plan_idle(input int from, input int to, input bit noisy);
        for (int c = from; c < to; c++) begin
            p_rst[c]   = 1'b0;
            p_start[c] = noisy;
            p_len[c]   = noisy ? '0 : CNT_W'($urandom_range(0, 31));
            p_base[c]  = DATA_W'($urandom);
            p_ack[c]   = 1'($urandom_range(0, 1));
            set_exp(c, 1'b0, hold_data, 1'b0, 1'b0, 1'b0, hold_cnt);
        end
    endtask

    // One burst requested in cycle s; word k goes out as base+k, the receiver raises ack
    // r cycles after req rises and drops it f cycles after req falls.
    task automatic plan_burst(input int s, input int len_in, input logic [DATA_W-1:0] b,
                              input bit hold_start, input bit fixed, input int stall_k,
                              input bit stall_wait, input int rst_k, output int nxt);
        int   L, t, w, r, f;
        bit   ended;
        logic [DATA_W-1:0] wd;
        L = (len_in > MAX_B) ? MAX_B : len_in;
        set_exp(s, 1'b0, hold_data, 1'b0, 1'b0, 1'b0, hold_cnt);
        p_rst[s]   = 1'b0;
        p_start[s] = 1'b1;
        p_len[s]   = CNT_W'(len_in);
        p_base[s]  = b;
        p_ack[s]   = 1'b0;
        t     = s + 1;
        ended = 1'b0;
        nxt   = t;
        for (int k = 0; k < L; k++) begin
            wd = b + DATA_W'(k);
            if (stall_k == k && !stall_wait) begin
                for (int c = t; c < t + TMO; c++) begin
                    set_exp(c, 1'b1, wd, 1'b1, 1'b0, 1'b0, k);
                    p_ack[c] = 1'b0;
                end
                set_exp(t + TMO, 1'b0, wd, 1'b1, 1'b0, 1'b1, k);
                p_ack[t + TMO] = 1'b0;
                hold_data = wd;
                hold_cnt  = k;
                nxt   = t + TMO + 1;
                ended = 1'b1;
                break;
            end
            r = fixed ? 1 : $urandom_range(1, 6);
            f = fixed ? 1 : $urandom_range(1, 6);
            for (int c = t; c <= t + r; c++) begin
                set_exp(c, 1'b1, wd, 1'b1, 1'b0, 1'b0, k);
                p_ack[c] = (c == t + r);
            end
            w = t + r + 1;
            if (rst_k == k) begin
                set_exp(w, 1'b0, wd, 1'b1, 1'b0, 1'b0, k + 1);
                p_ack[w] = 1'b1;
                p_rst[w] = 1'b1;
                hold_data = '0;
                hold_cnt  = 0;
                nxt   = w + 1;
                ended = 1'b1;
                break;
            end
            if (stall_k == k && stall_wait) begin
                for (int c = w; c < w + TMO; c++) begin
                    set_exp(c, 1'b0, wd, 1'b1, 1'b0, 1'b0, k + 1);
                    p_ack[c] = 1'b1;
                end
                set_exp(w + TMO, 1'b0, wd, 1'b1, 1'b0, 1'b1, k + 1);
                p_ack[w + TMO] = 1'b1;
                hold_data = wd;
                hold_cnt  = k + 1;
                nxt   = w + TMO + 1;
                ended = 1'b1;
                break;
            end
            for (int c = w; c <= w + f; c++) begin
                set_exp(c, 1'b0, wd, 1'b1, 1'b0, 1'b0, k + 1);
                p_ack[c] = (c < w + f);
            end
            t = w + f + 1;
        end
        if (!ended) begin
            wd = b + DATA_W'(L - 1);
            set_exp(t, 1'b0, wd, 1'b1, 1'b1, 1'b0, L);
            p_ack[t] = 1'b0;
            hold_data = wd;
            hold_cnt  = L;
            nxt = t + 1;
        end
        for (int c = s + 1; c < nxt; c++) begin
            p_start[c] = hold_start;
            if (hold_start) begin
                p_len[c]  = CNT_W'($urandom_range(0, 31));
                p_base[c] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic run_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            applyStimulus(cyc);
        end
    endtask

    task automatic clear_stats();
        rise_words.delete();
        done_count    = 0;
        err_count     = 0;
        last_done_cyc = -1;
        last_err_cyc  = -1;
        cnt_at_done   = -1;
        cnt_at_err    = -1;
    endtask

    task automatic check_word(input string name, input int idx, input logic [DATA_W-1:0] expv);
        logic [31:0] act;
        act = (idx < rise_words.size()) ? 32'(rise_words[idx]) : 32'hxxxx_xxxx;
        checkOutput(name, idx, act, 32'(expv));
    endtask

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < N && e_chk[cyc]) begin
            checkOutput("req",      cyc, 32'(req),      32'(e_req[cyc]));
            checkOutput("data",     cyc, 32'(data),     32'(e_data[cyc]));
            checkOutput("busy",     cyc, 32'(busy),     32'(e_busy[cyc]));
            checkOutput("done",     cyc, 32'(done),     32'(e_done[cyc]));
            checkOutput("err",      cyc, 32'(err),      32'(e_err[cyc]));
            checkOutput("xfer_cnt", cyc, 32'(xfer_cnt), 32'(e_cnt[cyc]));
        end
        if (req === 1'b1 && prev_req !== 1'b1) rise_words.push_back(data);
        if (done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
            cnt_at_done   = int'(xfer_cnt);
        end
        if (err === 1'b1) begin
            err_count++;
            last_err_cyc = cyc;
            cnt_at_err   = int'(xfer_cnt);
        end
        prev_req = req;
    end

    initial begin
        int cur, s, nxt, nxt2, gap, L, pick, sk, rk;
        bit sw;
        for (int i = 0; i < N; i++) begin
            p_rst[i]   = 1'b0;
            p_start[i] = 1'b0;
            p_ack[i]   = 1'b0;
            p_len[i]   = CNT_W'($urandom_range(0, 31));
            p_base[i]  = DATA_W'($urandom);
            e_chk[i]   = 1'b0;
        end
        hold_data = '0;
        hold_cnt  = 0;
        prev_req  = 1'b0;
        clear_stats();

        p_rst[0] = 1'b1;
        p_rst[1] = 1'b1;
        set_exp(1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
        plan_idle(2, 4, 1'b0);
        applyStimulus(0);
        cur = 4;

        // Four words from A0 with a one-cycle receiver: 4 cycles per word.
        clear_stats();
        s = cur;
        plan_burst(s, 4, 8'hA0, 1'b0, 1'b1, -1, 1'b0, -1, nxt);
        plan_idle(nxt, nxt + 2, 1'b0);
        run_to(nxt);
        checkOutput("A_nwords", 0, 32'(rise_words.size()), 32'd4);
        check_word("A_word", 0, 8'hA0);
        check_word("A_word", 1, 8'hA1);
        check_word("A_word", 2, 8'hA2);
        check_word("A_word", 3, 8'hA3);
        checkOutput("A_done_count", 0, 32'(done_count), 32'd1);
        checkOutput("A_done_cycle", 0, 32'(last_done_cyc), 32'(s + 17));
        checkOutput("A_final_cnt", 0, 32'(cnt_at_done), 32'd4);
        cur = nxt + 2;

        // Data wraps from FF to 00.
        clear_stats();
        plan_burst(cur, 3, 8'hFE, 1'b0, 1'b1, -1, 1'b0, -1, nxt);
        plan_idle(nxt, nxt + 2, 1'b0);
        run_to(nxt);
        check_word("B_word", 0, 8'hFE);
        check_word("B_word", 1, 8'hFF);
        check_word("B_word", 2, 8'h00);
        checkOutput("B_done_count", 0, 32'(done_count), 32'd1);
        checkOutput("B_err_count", 0, 32'(err_count), 32'd0);
        cur = nxt + 2;

        // Oversized request is clamped to MAX_BURST words.
        clear_stats();
        plan_burst(cur, 20, 8'h30, 1'b0, 1'b0, -1, 1'b0, -1, nxt);
        plan_idle(nxt, nxt + 2, 1'b0);
        run_to(nxt);
        checkOutput("C_nwords", 0, 32'(rise_words.size()), 32'd16);
        check_word("C_word", 15, 8'h3F);
        checkOutput("C_final_cnt", 0, 32'(cnt_at_done), 32'd16);
        checkOutput("C_done_count", 0, 32'(done_count), 32'd1);
        cur = nxt + 2;

        // Receiver never acks the second word: err 8 cycles after that REQ entry.
        clear_stats();
        s = cur;
        plan_burst(s, 5, 8'h10, 1'b0, 1'b1, 1, 1'b0, -1, nxt);
        plan_idle(nxt, nxt + 2, 1'b0);
        run_to(nxt);
        checkOutput("D_err_count", 0, 32'(err_count), 32'd1);
        checkOutput("D_err_cycle", 0, 32'(last_err_cyc), 32'(s + 13));
        checkOutput("D_err_cnt", 0, 32'(cnt_at_err), 32'd1);
        checkOutput("D_done_count", 0, 32'(done_count), 32'd0);
        cur = nxt + 2;

        // Reset during WAITLOW of the second word, then start=1/len=0 noise, then a full burst.
        clear_stats();
        plan_burst(cur, 6, 8'h55, 1'b0, 1'b0, -1, 1'b0, 1, nxt);
        plan_idle(nxt, nxt + 5, 1'b1);
        plan_burst(nxt + 5, 6, 8'h70, 1'b0, 1'b0, -1, 1'b0, -1, nxt2);
        plan_idle(nxt2, nxt2 + 2, 1'b0);
        run_to(nxt + 5);
        checkOutput("E_done_count", 0, 32'(done_count), 32'd0);
        checkOutput("E_err_count", 0, 32'(err_count), 32'd0);
        run_to(nxt2);
        checkOutput("F_done_count", 0, 32'(done_count), 32'd1);
        checkOutput("F_final_cnt", 0, 32'(cnt_at_done), 32'd6);
        check_word("F_word", 7, 8'h75);
        cur = nxt2 + 2;

        // start held high through a burst, then a new burst on the first idle cycle.
        clear_stats();
        plan_burst(cur, 5, 8'hC0, 1'b1, 1'b0, -1, 1'b0, -1, nxt);
        plan_burst(nxt, 2, 8'h01, 1'b0, 1'b0, -1, 1'b0, -1, nxt2);
        plan_idle(nxt2, nxt2 + 2, 1'b0);
        run_to(nxt2);
        checkOutput("G_done_count", 0, 32'(done_count), 32'd2);
        checkOutput("G_nwords", 0, 32'(rise_words.size()), 32'd7);
        check_word("G_word", 4, 8'hC4);
        check_word("G_word", 5, 8'h01);
        cur = nxt2 + 2;

        // Receiver holds ack high after the third word: timeout in WAITLOW.
        clear_stats();
        plan_burst(cur, 3, 8'h80, 1'b0, 1'b0, 2, 1'b1, -1, nxt);
        plan_idle(nxt, nxt + 2, 1'b0);
        run_to(nxt);
        checkOutput("H_err_count", 0, 32'(err_count), 32'd1);
        checkOutput("H_err_cnt", 0, 32'(cnt_at_err), 32'd3);
        checkOutput("H_done_count", 0, 32'(done_count), 32'd0);
        cur = nxt + 2;

        for (int it = 0; it < 30; it++) begin
            if (cur > N - 700) break;
            gap = $urandom_range(0, 3);
            plan_idle(cur, cur + gap, 1'($urandom_range(0, 1)));
            L    = $urandom_range(1, 20);
            pick = $urandom_range(0, 9);
            sk   = -1;
            rk   = -1;
            sw   = 1'b0;
            if (pick == 0) sk = $urandom_range(0, ((L > MAX_B) ? MAX_B : L) - 1);
            if (pick == 1) begin
                sk = $urandom_range(0, ((L > MAX_B) ? MAX_B : L) - 1);
                sw = 1'b1;
            end
            if (pick == 2) rk = $urandom_range(0, ((L > MAX_B) ? MAX_B : L) - 1);
            plan_burst(cur + gap, L, DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                       sk, sw, rk, nxt);
            run_to(nxt - 1);
            cur = nxt;
        end
        plan_idle(cur, cur + 3, 1'b0);
        run_to(cur + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
